decoder3to8_strobe: RTL

Registered 3-to-8 binary-to-one-hot decoder with a valid/ready input handshake and a timed output strobe. It accepts a 3-bit index and drives the matching bit of `Y` high for `PULSE_LEN` cycles. It then holds all outputs low for `GAP_LEN` cycles before accepting the next index. It is the decode-side counterpart of the 8-to-3 encoder and drives one-of-eight select and enable lines from a binary index.

---
 rtl/decoder3to8_strobe.sv | 90 +++++++++
 1 files changed

// File: rtl/decoder3to8_strobe.sv
// Registered 3-to-8 one-hot decoder with valid/ready acceptance, a PULSE_LEN-cycle
// strobe on the selected Y bit, and a GAP_LEN-cycle all-zero gap before the next index.
module decoder3to8_strobe #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] A,
  output logic [7:0] Y,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_e;

  localparam logic [7:0] PULSE_M1 = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GAP_M1   = 8'(GAP_LEN - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] y_q, y_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  assign in_ready = (state_q == IDLE) & en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid && en) begin
          idx_d   = A;
          cnt_d   = PULSE_M1;
          state_d = ACTIVE;
        end
        ACTIVE: if (cnt_q == 8'd0) begin
          if (GAP_LEN > 0) begin
            state_d = GAP;
            cnt_d   = GAP_M1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
        GAP: if (cnt_q == 8'd0) state_d = IDLE;
             else cnt_d = cnt_q - 8'd1;
        default: state_d = IDLE;
      endcase
    end
    // Outputs are derived from the next state so they line up with it when registered.
    y_d    = (state_d == ACTIVE) ? (8'h01 << idx_d) : 8'h00;
    busy_d = (state_d != IDLE);
    done_d = (state_d == ACTIVE) && (cnt_d == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Y    = y_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
